// File: rtl/input_debouncer.sv
// Purpose: two-flop synchronise and debounce a switch vector; publish it after it holds steady.
// Latency: STABLE_CYCLES+3 clocks from a steady new raw_in value to stable_out/changed.
// Backpressure: none; free-running, and every bounce seen by the synchroniser restarts the window.
// Optional feature: define DEBOUNCE_GLITCH_CNT_EN to build the saturating glitch_count register.
module input_debouncer #(
   parameter int          WIDTH         = 8,
   parameter int unsigned STABLE_CYCLES = 24'd100_000,
   parameter int          CNT_W         = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] stable_out,
   output logic             changed,
   output logic             settling,
   output logic [7:0]       glitch_count
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_SETTLE = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic             changed_q, changed_d;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic             glitch_inc;
   logic [7:0]       glitch_q;
`endif

   // Synchroniser, FSM state, candidate, counter and published outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         state_q   <= ST_STABLE;
         cand_q    <= '0;
         cnt_q     <= '0;
         stable_q  <= '0;
         changed_q <= 1'b0;
      end else begin
         sync1_q   <= raw_in;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         stable_q  <= stable_d;
         changed_q <= changed_d;
      end
   end

   // Next-state: open a window on a difference, restart it on any bounce, publish when it expires.
   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      stable_d  = stable_q;
      changed_d = 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      glitch_inc = 1'b0;
`endif
      case (state_q)
         ST_STABLE: begin
            if (sync2_q != stable_q) begin
               cand_d  = sync2_q;
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (sync2_q != cand_q) begin
               cand_d = sync2_q;
               cnt_d  = '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
               glitch_inc = 1'b1;
`endif
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_STABLE;
               // A bounce back to the old value closes the window silently.
               if (cand_q != stable_q) begin
                  stable_d  = cand_q;
                  changed_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_STABLE;
      endcase
   end

`ifdef DEBOUNCE_GLITCH_CNT_EN
   // Saturating count of window restarts, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         glitch_q <= 8'h00;
      end else if (glitch_inc && (glitch_q != 8'hFF)) begin
         glitch_q <= glitch_q + 8'h01;
      end
   end
   assign glitch_count = glitch_q;
`else
   assign glitch_count = 8'h00;
`endif

   assign stable_out = stable_q;
   assign changed    = changed_q;
   assign settling   = (state_q == ST_SETTLE);

endmodule
